// File: rtl/mem_burst_master.sv
// Burst initiator for a single-port synchronous RAM with 1-cycle read latency.
// Optional activity counters are compiled in when MEM_BURST_PERF_EN is defined.
module mem_burst_master #(
    parameter int ADDR_LEN = 11,
    parameter int LEN_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_LEN-1:0] req_addr,
    input  logic [LEN_W-1:0]    req_len,
    input  logic                wdata_valid,
    output logic                wdata_ready,
    input  logic [31:0]         wdata,
    output logic                rdata_valid,
    input  logic                rdata_ready,
    output logic [31:0]         rdata,
    output logic                rdata_last,
    output logic                wr_done,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic                mem_wr_req,
    output logic [31:0]         mem_wr_data,
    input  logic [31:0]         mem_rd_data
`ifdef MEM_BURST_PERF_EN
    ,
    output logic [31:0]         perf_rd_words,
    output logic [31:0]         perf_wr_words
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          fifo_cnt_q, fifo_cnt_d;
    logic [1:0]          wr_ptr_q, wr_ptr_d;
    logic [1:0]          rd_ptr_q, rd_ptr_d;
    logic                inflight_q, inflight_d;
    logic                inflight_last_q, inflight_last_d;
    logic                wr_done_q, wr_done_d;
    logic [32:0]         fifo_mem_q [0:2];

    logic wr_accept;
    logic issue;
    logic push;
    logic pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Words already buffered plus the one in flight must leave room for the next return.
    always_comb begin
        wr_accept = (state_q == ST_WRITE) && wdata_valid;
        issue     = (state_q == ST_READ) &&
                    (({1'b0, fifo_cnt_q} + {2'b00, inflight_q}) < 3'd3);
        push      = inflight_q;
        pop       = (fifo_cnt_q != 2'd0) && rdata_ready;
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        cnt_d           = cnt_q;
        inflight_d      = issue;
        inflight_last_d = issue && (cnt_q == '0);
        wr_done_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    cnt_d   = req_len;
                    state_d = req_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (wr_accept) begin
                    addr_d = addr_q + ADDR_LEN'(1);
                    if (cnt_q == '0) begin
                        state_d   = ST_IDLE;
                        wr_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
            end
            ST_READ: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_LEN'(1);
                    if (cnt_q == '0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if ((fifo_cnt_q == 2'd0) && !inflight_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + 2'd1;
        end else if (pop && !push) begin
            fifo_cnt_d = fifo_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            cnt_q           <= '0;
            fifo_cnt_q      <= 2'd0;
            wr_ptr_q        <= 2'd0;
            rd_ptr_q        <= 2'd0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_done_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            cnt_q           <= cnt_d;
            fifo_cnt_q      <= fifo_cnt_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            wr_done_q       <= wr_done_d;
        end
    end

    // Storage needs no reset: the occupancy count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {inflight_last_q, mem_rd_data};
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign wdata_ready = (state_q == ST_WRITE);
    assign mem_wr_req  = wr_accept;
    assign mem_wr_data = wdata;
    assign mem_addr    = addr_q;
    assign rdata_valid = (fifo_cnt_q != 2'd0);
    assign rdata       = fifo_mem_q[rd_ptr_q][31:0];
    assign rdata_last  = rdata_valid && fifo_mem_q[rd_ptr_q][32];
    assign wr_done     = wr_done_q;

`ifdef MEM_BURST_PERF_EN
    logic [31:0] perf_rd_q, perf_rd_d;
    logic [31:0] perf_wr_q, perf_wr_d;

    always_comb begin
        perf_rd_d = perf_rd_q + (issue ? 32'd1 : 32'd0);
        perf_wr_d = perf_wr_q + (wr_accept ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_rd_q <= 32'd0;
            perf_wr_q <= 32'd0;
        end else begin
            perf_rd_q <= perf_rd_d;
            perf_wr_q <= perf_wr_d;
        end
    end

    assign perf_rd_words = perf_rd_q;
    assign perf_wr_words = perf_wr_q;
`endif

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master: bench-side RAM, shadow-memory model and a per-cycle comparer.
module tb_mem_burst_master;
    localparam int AW = 11;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic          wdata_valid = 1'b0;
    logic          wdata_ready;
    logic [31:0]   wdata = '0;
    logic          rdata_valid;
    logic          rdata_ready = 1'b0;
    logic [31:0]   rdata;
    logic          rdata_last;
    logic          wr_done;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_req;
    logic [31:0]   mem_wr_data;
    logic [31:0]   mem_rd_data;

    logic [31:0] ram [0:(1<<AW)-1];
    logic [31:0] shadow [0:(1<<AW)-1];

    logic [32:0]      exp_rd_q [$];
    logic [AW+31:0]   exp_wr_q [$];
    logic [32:0]      cmp_r;
    logic [AW+31:0]   cmp_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_burst_master #(.ADDR_LEN(AW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .rdata_last(rdata_last), .wr_done(wr_done),
        .mem_addr(mem_addr), .mem_wr_req(mem_wr_req), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    always @(posedge clk) begin
        if (mem_wr_req) ram[mem_addr] <= mem_wr_data;
        mem_rd_data <= ram[mem_addr];
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check("last_only_with_valid", {63'd0, rdata_last & ~rdata_valid}, 64'd0);
            if (mem_wr_req) begin
                check("wr_req_in_write", {63'd0, wdata_ready}, 64'd1);
                if (exp_wr_q.size() == 0) begin
                    check("unexpected_write", {63'd0, mem_wr_req}, 64'd0);
                end else begin
                    cmp_w = exp_wr_q.pop_front();
                    check("wr_addr", {53'd0, mem_addr}, {53'd0, cmp_w[AW+31:32]});
                    check("wr_data", {32'd0, mem_wr_data}, {32'd0, cmp_w[31:0]});
                    $display("write addr=%03h data=%08h", mem_addr, mem_wr_data);
                end
            end
            if (rdata_valid && rdata_ready) begin
                if (exp_rd_q.size() == 0) begin
                    check("unexpected_read", {63'd0, rdata_valid}, 64'd0);
                end else begin
                    cmp_r = exp_rd_q.pop_front();
                    check("rd_data", {32'd0, rdata}, {32'd0, cmp_r[31:0]});
                    check("rd_last", {63'd0, rdata_last}, {63'd0, cmp_r[32]});
                    $display("read  data=%08h last=%0b", rdata, rdata_last);
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) return;
        end
        check("idle_timeout", {63'd0, req_ready}, 64'd1);
    endtask

    task automatic start_req(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
        wait_idle();
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_len   = l;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 11'h555;
        req_len   = 4'hA;
        req_write = ~w;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] l,
                            input logic [31:0] base, input logic [31:0] step, input int stall_every);
        logic [AW-1:0] ad;
        for (int i = 0; i <= int'(l); i++) begin
            ad = a + AW'(i);
            shadow[ad] = base + step * i;
            exp_wr_q.push_back({ad, base + step * i});
        end
        start_req(1'b1, a, l);
        for (int i = 0; i <= int'(l); i++) begin
            if (stall_every != 0 && (i % stall_every) == 1) begin
                wdata_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            wdata_valid = 1'b1;
            wdata       = base + step * i;
            @(posedge clk);
            #1;
        end
        wdata_valid = 1'b0;
        wdata       = 32'hDEADBEEF;
        @(negedge clk);
        check("wr_done_pulse", {63'd0, wr_done}, 64'd1);
        check("ready_after_write", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        check("wr_done_one_cycle", {63'd0, wr_done}, 64'd0);
        check("write_queue_drained", exp_wr_q.size(), 64'd0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] l, input int mode);
        logic [AW-1:0] ad;
        for (int i = 0; i <= int'(l); i++) begin
            ad = a + AW'(i);
            exp_rd_q.push_back({(i == int'(l)), shadow[ad]});
        end
        rdata_ready = 1'b1;
        start_req(1'b0, a, l);
        for (int k = 0; k < 300; k++) begin
            rdata_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            @(posedge clk);
            #1;
            if (exp_rd_q.size() == 0) break;
        end
        check("read_queue_drained", exp_rd_q.size(), 64'd0);
        rdata_ready = 1'b0;
        wait_idle();
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_mem_wr_req", {63'd0, mem_wr_req}, 64'd0);
        check("rst_rdata_valid", {63'd0, rdata_valid}, 64'd0);
        check("rst_wr_done", {63'd0, wr_done}, 64'd0);
        check("rst_mem_addr", {53'd0, mem_addr}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_wdata_ready", {63'd0, wdata_ready}, 64'd0);

        // Write 0x010..0x013 with 0xA0..0xA3.
        do_write(11'h010, 4'd3, 32'hA0, 32'd1, 0);
        check("ram_0x013", {32'd0, ram[11'h013]}, 64'hA3);

        // First read with fixed latency: first word three cycles after the handshake.
        exp_rd_q.push_back({1'b0, 32'hA0});
        exp_rd_q.push_back({1'b0, 32'hA1});
        exp_rd_q.push_back({1'b0, 32'hA2});
        exp_rd_q.push_back({1'b1, 32'hA3});
        rdata_ready = 1'b1;
        start_req(1'b0, 11'h010, 4'd3);
        @(negedge clk);
        check("t1_rvalid", {63'd0, rdata_valid}, 64'd0);
        @(negedge clk);
        check("t2_rvalid", {63'd0, rdata_valid}, 64'd0);
        @(negedge clk);
        check("t3_rvalid", {63'd0, rdata_valid}, 64'd1);
        check("t3_rdata", {32'd0, rdata}, 64'hA0);
        check("t3_rlast", {63'd0, rdata_last}, 64'd0);
        @(negedge clk);
        check("t4_rdata", {32'd0, rdata}, 64'hA1);
        @(negedge clk);
        check("t5_rdata", {32'd0, rdata}, 64'hA2);
        @(negedge clk);
        check("t6_rdata", {32'd0, rdata}, 64'hA3);
        check("t6_rlast", {63'd0, rdata_last}, 64'd1);
        @(negedge clk);
        check("t7_rvalid", {63'd0, rdata_valid}, 64'd0);
        rdata_ready = 1'b0;
        wait_idle();

        // Same read under consumer back-pressure.
        do_read(11'h010, 4'd3, 1);

        // Stalled write source, then back-pressured read.
        do_write(11'h100, 4'd5, 32'h1000, 32'd7, 2);
        do_read(11'h100, 4'd5, 1);

        // Address wrap at the top of the RAM.
        do_write(11'h7FF, 4'd1, 32'h11, 32'h11, 0);
        check("ram_0x7ff", {32'd0, ram[11'h7FF]}, 64'h11);
        check("ram_0x000", {32'd0, ram[11'h000]}, 64'h22);
        do_read(11'h7FF, 4'd1, 0);

        // Maximum-length burst straddling the wrap.
        do_write(11'h7F8, 4'd15, 32'hC0DE0000, 32'h101, 3);
        do_read(11'h7F8, 4'd15, 1);
        do_read(11'h7F8, 4'd15, 0);

        // Reset while the third read word is pending.
        exp_rd_q.push_back({1'b0, 32'hA0});
        exp_rd_q.push_back({1'b0, 32'hA1});
        rdata_ready = 1'b1;
        start_req(1'b0, 11'h010, 4'd3);
        repeat (4) @(negedge clk);
        #1;
        rst_n = 1'b0;
        exp_rd_q.delete();
        #1;
        check("midrst_req_ready", {63'd0, req_ready}, 64'd1);
        check("midrst_rdata_valid", {63'd0, rdata_valid}, 64'd0);
        check("midrst_rdata_last", {63'd0, rdata_last}, 64'd0);
        check("midrst_mem_addr", {53'd0, mem_addr}, 64'd0);
        check("midrst_mem_wr_req", {63'd0, mem_wr_req}, 64'd0);
        check("midrst_wdata_ready", {63'd0, wdata_ready}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdata_ready = 1'b0;
        do_read(11'h7FF, 4'd0, 0);
        do_read(11'h013, 4'd0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
